// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - block-copy initiator for the shared data-memory port
//
// Purpose:
//   Moves a run of 8-bit words from a source region to a destination region of
//   the data memory without CPU involvement. Each word takes one READ cycle
//   (address = src) and one WRITE cycle (address = dst, data = registered read
//   data). The engine drives the memory port only while busy; an external mux
//   selected by busy hands the port back to the datapath otherwise.
//
// Optional feature:
//   MEM_COPY_FILL_EN - adds fillMode/fillValue. With fillMode=1 the READ phase
//   is skipped and fillValue is written to every destination word.
//
// Ports:
//   clk          in   clock, rising edge
//   RST          in   asynchronous active-high reset
//   start        in   launch a copy (sampled in IDLE only)
//   abort        in   stop an active copy (sampled in READ/WRITE)
//   srcAddr      in   source base, bits [AW-1:0] used
//   dstAddr      in   destination base, bits [AW-1:0] used
//   length       in   word count, saturates to MEM_WORDS
//   fillMode     in   (MEM_COPY_FILL_EN) write fillValue instead of copying
//   fillValue    in   (MEM_COPY_FILL_EN) constant written in fill mode
//   busy         out  high in READ and WRITE
//   done         out  one-cycle completion pulse
//   wordsDone    out  words written in the current or last copy
//   memAddress   out  memory address, upper 8-AW bits always 0
//   memWriteData out  memory write data
//   MemRead      out  memory read strobe
//   MemWrite     out  memory write strobe
//   memReadData  in   registered memory read data (valid the cycle after MemRead)

module mem_copy_engine #(
  parameter int MEM_WORDS = 32,
  parameter int AW        = 5
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] srcAddr,
  input  logic [7:0] dstAddr,
  input  logic [5:0] length,
`ifdef MEM_COPY_FILL_EN
  input  logic       fillMode,
  input  logic [7:0] fillValue,
`endif
  output logic       busy,
  output logic       done,
  output logic [5:0] wordsDone,
  output logic [7:0] memAddress,
  output logic [7:0] memWriteData,
  output logic       MemRead,
  output logic       MemWrite,
  input  logic [7:0] memReadData
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [6:0] MAX_LEN = 7'(MEM_WORDS);

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [5:0]    len_q;
  logic [5:0]    words_q;
  logic [5:0]    length_sat;
  logic          last_word;
  logic          fill_active;

  // Only the low AW address bits are significant; the rest are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{srcAddr[7:AW], dstAddr[7:AW]};

  assign length_sat = ({1'b0, length} > MAX_LEN) ? MAX_LEN[5:0] : length;

  // The word being written in this WRITE cycle is the final one of the run.
  assign last_word = (words_q + 6'd1) == len_q;

`ifdef MEM_COPY_FILL_EN
  logic       fill_mode_q;
  logic [7:0] fill_value_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      fill_mode_q  <= 1'b0;
      fill_value_q <= 8'd0;
    end else if (state == S_IDLE && start) begin
      fill_mode_q  <= fillMode;
      fill_value_q <= fillValue;
    end
  end

  assign fill_active = fill_mode_q;
`else
  assign fill_active = 1'b0;
`endif

  // State register plus the address/count registers the outputs decode from.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= 6'd0;
      words_q <= 6'd0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q   <= srcAddr[AW-1:0];
            dst_q   <= dstAddr[AW-1:0];
            len_q   <= length_sat;
            words_q <= 6'd0;
          end
        end
        S_WRITE: begin
          // AW-bit arithmetic gives the modulo-MEM_WORDS wrap for free.
          src_q   <= src_q + AW'(1);
          dst_q   <= dst_q + AW'(1);
          words_q <= words_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length_sat == 6'd0) begin
            state_next = S_DONE;
          end else begin
`ifdef MEM_COPY_FILL_EN
            state_next = fillMode ? S_WRITE : S_READ;
`else
            state_next = S_READ;
`endif
          end
        end
      end
      S_READ: begin
        // An abort here discards the read: nothing is written for it.
        state_next = abort ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        // The write in this cycle completes and is counted even on abort.
        if (abort || last_word) begin
          state_next = S_DONE;
        end else begin
          state_next = fill_active ? S_WRITE : S_READ;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Memory-side outputs decode directly from the flops so an asynchronous
  // reset drops the strobes immediately.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    memAddress   = 8'd0;
    memWriteData = 8'd0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    case (state)
      S_READ: begin
        busy       = 1'b1;
        MemRead    = 1'b1;
        memAddress = {{(8-AW){1'b0}}, src_q};
      end
      S_WRITE: begin
        busy       = 1'b1;
        MemWrite   = 1'b1;
        memAddress = {{(8-AW){1'b0}}, dst_q};
`ifdef MEM_COPY_FILL_EN
        memWriteData = fill_active ? fill_value_q : memReadData;
`else
        memWriteData = memReadData;
`endif
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign wordsDone = words_q;

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Block-copy initiator that drives the data-memory port (address, write data, MemRead, MemWrite) and consumes its registered read data. It moves a run of 8-bit words from a source region to a destination region of the 32-word data memory with no CPU involvement. It sits beside the datapath and shares the memory port through an external mux selected by `busy`.

## Interface
Parameters:
- `MEM_WORDS`, 32: memory depth. Must be a power of two. Addresses wrap modulo this value.
- `AW`, 5: log2(`MEM_WORDS`). This is the significant address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous and active-high.
- `start` in 1: sampled only in IDLE. Launches a copy.
- `abort` in 1: stops an active copy.
- `srcAddr` in 8: source base. Only bits [AW-1:0] are used.
- `dstAddr` in 8: destination base. Only bits [AW-1:0] are used.
- `length` in 6: word count, 0..32. Values above 32 saturate to 32.
- `busy` out 1: high in READ and WRITE.
- `done` out 1: one-cycle pulse in DONE.
- `wordsDone` out 6: words written so far in the current or last copy.
- `memAddress` out 8: memory address. Upper 8-AW bits are always 0.
- `memWriteData` out 8: write data to the memory.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe.
- `memReadData` in 8: registered memory read data, valid the cycle after MemRead.

## Operation
- States: IDLE, READ, WRITE, DONE. State, counters and address registers are flops. Memory-side outputs decode combinationally from these flops.
- IDLE:
  - All strobes are 0.
  - On `start`=1, latch src, dst and saturated length, and clear `wordsDone`.
  - If length is 0, go to DONE. Otherwise go to READ.
- READ:
  - `MemRead`=1, `memAddress`=current src.
  - Next state is WRITE.
- WRITE:
  - `MemWrite`=1, `memAddress`=current dst, `memWriteData`=`memReadData`.
  - At the edge: src and dst each increment modulo `MEM_WORDS`, and `wordsDone` increments.
  - If the remaining count reaches 0, go to DONE. Otherwise go to READ.
- DONE: `done`=1 for one cycle, then go to IDLE. `wordsDone` holds until the next `start`.
- `abort`:
  - Sampled in READ or WRITE; forces DONE at the next edge.
  - A WRITE on the abort cycle still completes and is counted.
  - A READ on the abort cycle is discarded.
  - Ignored in IDLE and DONE.
- `start` is ignored outside IDLE.
- Address arithmetic is AW-bit modulo. Example: src=30 with length 4 reads 30, 31, 0, 1.
- Overlap is a forward, ascending copy with no overlap protection. If dst lies in (src, src+len), already-written words are re-read.
- Idle outputs: `memAddress`=0, `memWriteData`=0. `MemRead` and `MemWrite` are never high together.

## Timing
- `start` at edge E0: the first READ cycle follows E0.
- Throughput is 2 cycles per word. A copy of N≥1 words occupies 2N cycles, and `done` is high in cycle 2N+1 after E0.
- N=0: `done` is high in the cycle after E0. No memory strobes are issued.
- `busy` rises the cycle after E0 and falls in the DONE cycle.
- Back-to-back: `start` may be asserted in DONE but is ignored. The earliest accepted `start` is in the first IDLE cycle.
- Reset values: state=IDLE, `busy`=0, `done`=0, `wordsDone`=0, `memAddress`=0, `memWriteData`=0, `MemRead`=0, `MemWrite`=0.
- `RST` mid-copy: strobes drop immediately (asynchronous). Remaining words are not written, and words already written stay written.

## Configuration
- `MEM_COPY_FILL_EN` defined:
  - Adds inputs `fillMode` (1 bit) and `fillValue` (8 bits), both sampled with `start`.
  - With `fillMode`=1, READ is skipped. The engine moves IDLE to WRITE to ... to DONE, writing `fillValue` to each dst.
  - Throughput is 1 cycle per word, and `done` is high in cycle N+1.
  - `abort` and wrap rules are unchanged.
- `MEM_COPY_FILL_EN` undefined: the fill ports do not exist and the engine always copies.

## Test plan
Memory reset contents are mem[i]=i for i=0..15 and mem[i]=16-i (8-bit) for i=16..31.
- Copy src=2, dst=20, len=3 → mem[20..22]=2,3,4.
  - `done` high exactly 7 cycles after the start edge; `wordsDone`=3.
  - Strobes alternate R,W,R,W,R,W.
- Wrap: src=30, dst=5, len=4 → reads 30,31,0,1; mem[5..8]=0xF2,0xF1,0x00,0x01.
- len=0 → `done` the next cycle, no strobes. len=40 → saturates to 32 and `wordsDone`=32.
- `abort` during the 2nd WRITE of len=5 → `wordsDone`=2, `done` the next cycle, only 2 writes issued.
- `RST` pulsed during a READ → strobes 0 immediately, state IDLE, `busy`=0. A new `start` afterwards copies correctly.
- With `MEM_COPY_FILL_EN`: fillMode=1, fillValue=0xA5, dst=10, len=4.
  - mem[10..13]=0xA5, `done` 5 cycles after start, `MemRead` never asserted.
